// File: rtl/fcw_sweep_ctrl.sv
// fcw_sweep_ctrl: linear FCW staircase sequencer for the DDFS accumulator.
// Ports: clk_i/rst_i (sync, active-high), cfg_* valid/ready config bus,
//        start_i/abort_i control, fcw_o/phase_clr_o to the accumulator,
//        busy_o/done_o/step_idx_o status.
module fcw_sweep_ctrl #(
    parameter int W  = 32,
    parameter int NW = 16,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cfg_valid_i,
    output logic          cfg_ready_o,
    input  logic [W-1:0]  cfg_start_fcw_i,
    input  logic [W-1:0]  cfg_step_i,
    input  logic [NW-1:0] cfg_nsteps_i,
    input  logic [CW-1:0] cfg_dwell_i,
    input  logic          cfg_repeat_i,
    input  logic          cfg_phase_clr_i,
    input  logic          start_i,
    input  logic          abort_i,
    output logic [W-1:0]  fcw_o,
    output logic          phase_clr_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [NW-1:0] step_idx_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;

    // shadow configuration
    logic [W-1:0]  start_q, start_d;
    logic [W-1:0]  step_q, step_d;
    logic [NW-1:0] nsteps_q, nsteps_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic          rep_q, rep_d;
    logic          pclr_q, pclr_d;

    // sweep progress and registered outputs
    logic [W-1:0]  fcw_q, fcw_d;
    logic [NW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phclr_q, phclr_d;
    logic          done_q, done_d;

    // A config offered in the start cycle bypasses the shadow registers;
    // it is latched on the same edge, so RUN then sees it in the shadow.
    logic [W-1:0]  eff_start;
    logic          eff_pclr;

    assign eff_start = cfg_valid_i ? cfg_start_fcw_i : start_q;
    assign eff_pclr  = cfg_valid_i ? cfg_phase_clr_i : pclr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            start_q  <= '0;
            step_q   <= '0;
            nsteps_q <= '0;
            dwell_q  <= '0;
            rep_q    <= 1'b0;
            pclr_q   <= 1'b0;
            fcw_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            phclr_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            step_q   <= step_d;
            nsteps_q <= nsteps_d;
            dwell_q  <= dwell_d;
            rep_q    <= rep_d;
            pclr_q   <= pclr_d;
            fcw_q    <= fcw_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            phclr_q  <= phclr_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        step_d   = step_q;
        nsteps_d = nsteps_q;
        dwell_d  = dwell_q;
        rep_d    = rep_q;
        pclr_d   = pclr_q;
        fcw_d    = fcw_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        phclr_d  = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cfg_valid_i) begin
                    start_d  = cfg_start_fcw_i;
                    step_d   = cfg_step_i;
                    nsteps_d = cfg_nsteps_i;
                    dwell_d  = cfg_dwell_i;
                    rep_d    = cfg_repeat_i;
                    pclr_d   = cfg_phase_clr_i;
                end
                if (start_i) begin
                    fcw_d   = eff_start;
                    idx_d   = '0;
                    cnt_d   = '0;
                    phclr_d = eff_pclr;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    fcw_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q != dwell_q) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (idx_q != nsteps_q) begin
                    fcw_d = fcw_q + step_q;
                    idx_d = idx_q + NW'(1);
                    cnt_d = '0;
                end else if (rep_q) begin
                    fcw_d   = start_q;
                    idx_d   = '0;
                    cnt_d   = '0;
                    phclr_d = pclr_q;
                end else begin
                    // one-shot end: fcw and step_idx hold final values
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cfg_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q == RUN);
    assign fcw_o       = fcw_q;
    assign phase_clr_o = phclr_q;
    assign done_o      = done_q;
    assign step_idx_o  = idx_q;

endmodule

// File: tb/tb_fcw_sweep_ctrl.sv
// tb_fcw_sweep_ctrl: directed and randomized sweeps for fcw_sweep_ctrl,
// compared cycle by cycle against a staircase model (start + v*step).
module tb_fcw_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_start_fcw;
    logic [31:0] cfg_step;
    logic [15:0] cfg_nsteps;
    logic [15:0] cfg_dwell;
    logic        cfg_repeat;
    logic        cfg_phase_clr;
    logic        start;
    logic        abort;
    logic [31:0] fcw;
    logic        phase_clr;
    logic        busy;
    logic        done;
    logic [15:0] step_idx;

    int checks = 0;
    int failures = 0;

    fcw_sweep_ctrl #(.W(32), .NW(16), .CW(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cfg_valid_i    (cfg_valid),
        .cfg_ready_o    (cfg_ready),
        .cfg_start_fcw_i(cfg_start_fcw),
        .cfg_step_i     (cfg_step),
        .cfg_nsteps_i   (cfg_nsteps),
        .cfg_dwell_i    (cfg_dwell),
        .cfg_repeat_i   (cfg_repeat),
        .cfg_phase_clr_i(cfg_phase_clr),
        .start_i        (start),
        .abort_i        (abort),
        .fcw_o          (fcw),
        .phase_clr_o    (phase_clr),
        .busy_o         (busy),
        .done_o         (done),
        .step_idx_o     (step_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [31:0] s, input logic [31:0] stp,
                           input logic [15:0] n, input logic [15:0] d,
                           input logic r, input logic p);
        cfg_start_fcw = s;
        cfg_step      = stp;
        cfg_nsteps    = n;
        cfg_dwell     = d;
        cfg_repeat    = r;
        cfg_phase_clr = p;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_fcw"}, fcw, 0);
        chk({tag, "_pclr"}, phase_clr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_idx"}, step_idx, 0);
        chk({tag, "_rdy"}, cfg_ready, 1);
    endtask

    // Called right after the start edge: walks the whole one-shot
    // staircase and ends on the first idle cycle (done pulse).
    task automatic expect_sweep(input logic [31:0] s, input logic [31:0] stp,
                                input int n, input int d, input logic p);
        logic [31:0] e;
        for (int v = 0; v <= n; v++) begin
            e = s + stp * 32'(v);
            for (int k = 0; k <= d; k++) begin
                chk("sw_busy", busy, 1);
                chk("sw_fcw", fcw, e);
                chk("sw_idx", step_idx, 64'(v));
                chk("sw_pclr", phase_clr, (p && v == 0 && k == 0));
                chk("sw_done", done, 0);
                chk("sw_rdy", cfg_ready, 0);
                tick();
            end
        end
        e = s + stp * 32'(n);
        chk("end_busy", busy, 0);
        chk("end_done", done, 1);
        chk("end_fcw", fcw, e);
        chk("end_rdy", cfg_ready, 1);
    endtask

    initial begin
        logic [31:0] rs, rstp;
        int          rn, rd, v;
        logic        rp;

        rst = 1'b1;
        cfg_valid = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(32'h0, 32'h0, 16'd0, 16'd0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        chk_reset("rst");

        // basic up-sweep: config first, start in a later cycle
        set_cfg(32'h0000_1000, 32'h100, 16'd3, 16'd1, 1'b0, 1'b0);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("cfg_only_busy", busy, 0);
        chk("cfg_only_rdy", cfg_ready, 1);
        set_cfg(32'hFFFF_0000, 32'h7, 16'd9, 16'd9, 1'b1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_sweep(32'h0000_1000, 32'h100, 3, 1, 1'b0);
        tick();
        chk("up_hold_fcw", fcw, 32'h1300);
        chk("up_done_low", done, 0);

        // down-sweep with wrap, config and start in the same cycle
        set_cfg(32'h10, 32'hFFFF_FFF0, 16'd2, 16'd0, 1'b0, 1'b0);
        cfg_valid = 1'b1;
        start = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start = 1'b0;
        expect_sweep(32'h10, 32'hFFFF_FFF0, 2, 0, 1'b0);
        chk("wrap_last", fcw, 32'hFFFF_FFF0);
        tick();

        // repeat with phase clear; cfg_valid and start in RUN ignored
        set_cfg(32'h2000_0000, 32'h0100_0000, 16'd1, 16'd2, 1'b1, 1'b1);
        cfg_valid = 1'b1;
        start = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            v = (c % 6) / 3;
            chk("rep_busy", busy, 1);
            chk("rep_rdy", cfg_ready, 0);
            chk("rep_fcw", fcw, 32'h2000_0000 + 32'h0100_0000 * 32'(v));
            chk("rep_idx", step_idx, 64'(v));
            chk("rep_pclr", phase_clr, (c % 6) == 0);
            chk("rep_done", done, 0);
            if (c == 4) begin
                cfg_valid = 1'b1;
                set_cfg(32'hDEAD_BEEF, 32'h1, 16'd0, 16'd0, 1'b0, 1'b0);
                start = 1'b1;
            end
            if (c == 6) begin
                cfg_valid = 1'b0;
                start = 1'b0;
            end
            if (c == 9) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        chk("abort_fcw", fcw, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pclr", phase_clr, 0);
        chk("abort_idx", step_idx, 0);

        // abort in IDLE ignored; shadow kept the pre-RUN config
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_rdy", cfg_ready, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("shadow_kept", fcw, 32'h2000_0000);
        chk("shadow_pclr", phase_clr, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort2_busy", busy, 0);

        // reset mid-sweep at step 2, then start with cleared config
        set_cfg(32'hABC0_0000, 32'h1, 16'd5, 16'd0, 1'b0, 1'b1);
        cfg_valid = 1'b1;
        start = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start = 1'b0;
        tick();
        tick();
        chk("mid_idx", step_idx, 2);
        chk("mid_fcw", fcw, 32'hABC0_0002);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("midrst");
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_sweep(32'h0, 32'h0, 0, 0, 1'b0);
        tick();

        // degenerate single value, then back-to-back start on done
        set_cfg(32'h1234_5678, 32'h5, 16'd0, 16'd0, 1'b0, 1'b1);
        cfg_valid = 1'b1;
        start = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start = 1'b0;
        chk("deg_busy", busy, 1);
        chk("deg_fcw", fcw, 32'h1234_5678);
        chk("deg_pclr", phase_clr, 1);
        tick();
        chk("deg_idle", busy, 0);
        chk("deg_done", done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_fcw", fcw, 32'h1234_5678);
        chk("b2b_pclr", phase_clr, 1);
        chk("b2b_done", done, 0);
        tick();
        chk("b2b_end", done, 1);
        tick();

        // randomized one-shot sweeps
        for (int it = 0; it < 8; it++) begin
            rs   = $urandom;
            rstp = $urandom;
            rn   = int'($urandom_range(0, 4));
            rd   = int'($urandom_range(0, 3));
            rp   = 1'($urandom_range(0, 1));
            set_cfg(rs, rstp, 16'(rn), 16'(rd), 1'b0, rp);
            cfg_valid = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                start = 1'b1;
                tick();
            end else begin
                tick();
                cfg_valid = 1'b0;
                start = 1'b1;
                tick();
            end
            cfg_valid = 1'b0;
            start = 1'b0;
            set_cfg($urandom, $urandom, 16'd7, 16'd7, 1'b1, 1'b1);
            expect_sweep(rs, rstp, rn, rd, rp);
            tick();
            chk("rnd_done_low", done, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fcw_sweep_ctrl.md
# fcw_sweep_ctrl

Frequency-sweep sequencer for the DDFS phase accumulator. It drives the accumulator's 32-bit frequency control word (FCW) through a programmed linear staircase: a start FCW, a signed step, a step count, and a dwell time per step. It also issues an optional phase-clear pulse at sweep start and reports busy/done status to the system controller. It sits between the configuration bus and the accumulator's `fcw` input.

## Interface
- `W`, 32, FCW / step width (matches accumulator width)
- `NW`, 16, step-count width
- `CW`, 16, dwell-counter width
- `clk` in 1: single system clock, rising edge
- `rst` in 1: reset, synchronous and active-high
- `cfg_valid` in 1: configuration offered
- `cfg_ready` out 1: configuration accepted when high (`cfg_valid & cfg_ready`)
- `cfg_start_fcw` in W: first FCW of sweep
- `cfg_step` in W: per-step FCW increment, two's complement
- `cfg_nsteps` in NW: number of increments after the start value
- `cfg_dwell` in CW: hold time per FCW value, in cycles minus 1
- `cfg_repeat` in 1: 0 = one-shot, 1 = restart sweep until abort
- `cfg_phase_clr` in 1: pulse `phase_clr` at each sweep (re)start
- `start` in 1: begin sweep (level sampled, acted on in IDLE only)
- `abort` in 1: terminate sweep
- `fcw` out W: registered FCW to accumulator
- `phase_clr` out 1: one-cycle accumulator clear request
- `busy` out 1: sweep in progress
- `done` out 1: one-cycle pulse on normal one-shot completion
- `step_idx` out NW: index of the FCW value currently on `fcw`

## Operation
- Two states:
  - **IDLE**: `cfg_ready` = 1, `busy` = 0.
  - **RUN**: `cfg_ready` = 0, `busy` = 1.
- Config is latched into shadow registers on `cfg_valid & cfg_ready`. In RUN, `cfg_valid` is ignored and has no effect on the sweep in progress.
- **Start from IDLE:** on `start`, the block loads:
  - `fcw` ← start_fcw
  - `step_idx` ← 0
  - dwell counter ← 0
  - `phase_clr` ← shadow phase_clr
  - state → RUN
- **Same-cycle config and start:** if `cfg_valid` and `start` are both high in IDLE, the config presented in that cycle is used for the sweep (bypass of the shadow registers). It is also latched.
- **RUN, each cycle:** if the dwell counter ≠ dwell, the counter increments. Otherwise:
  - If `step_idx` ≠ nsteps: `fcw` ← `fcw` + step (modulo 2^W, wrap-around allowed and intended), `step_idx`++, counter ← 0.
  - If `step_idx` = nsteps and repeat = 1: `fcw` ← start_fcw, `step_idx` ← 0, counter ← 0, `phase_clr` pulses if enabled. The block stays in RUN.
  - If `step_idx` = nsteps and repeat = 0: state → IDLE, `done` pulses, `fcw` holds its final value.
- **abort in RUN:** has priority over all step/end actions. Next edge: state → IDLE, `fcw` ← 0, `step_idx` ← 0, no `done`, no `phase_clr`. `abort` in IDLE is ignored. `start` in RUN is ignored.
- **Degenerate configs:** nsteps = 0 gives a single FCW value. dwell = 0 changes FCW every cycle.
- **Reset:** forces IDLE and clears all shadow registers. `rst` overrides every other input in the same cycle. A mid-sweep reset behaves like an abort with cleared config.

## Timing
- Reset values: `fcw` = 0, `phase_clr` = 0, `busy` = 0, `done` = 0, `step_idx` = 0, `cfg_ready` = 1.
- All outputs are registered except `cfg_ready`, which is decoded from the state register.
- Latency: with `start` sampled at edge t, `fcw` = start_fcw, `busy` = 1 and `phase_clr` = 1 are valid after edge t.
- `phase_clr` lasts exactly one cycle, coincident with the first cycle of `fcw` = start_fcw.
- Each FCW value is held for exactly dwell+1 cycles.
- One-shot sweep duration is (nsteps+1)·(dwell+1) cycles of `busy` = 1.
- `done` = 1 for one cycle, aligned with the first cycle of `busy` = 0.
- Repeat mode has no gap cycle between the last value and the restarted start_fcw.
- A new `start` is accepted in the cycle `done` is high, so back-to-back sweeps lose one idle cycle.

## Test plan
- **Basic up-sweep:** start_fcw = 0x0000_1000, step = 0x100, nsteps = 3, dwell = 1, one-shot.
  - Required: `fcw` = 0x1000, 0x1100, 0x1200, 0x1300, each held 2 cycles.
  - `busy` high for 8 cycles, then `done` 1 cycle. `fcw` stays 0x1300.
- **Down-sweep with wrap:** start_fcw = 0x0000_0010, step = 0xFFFF_FFF0 (−16), nsteps = 2, dwell = 0.
  - Required: `fcw` = 0x10, 0x0, 0xFFFF_FFF0 on consecutive cycles.
- **Repeat with phase clear:** nsteps = 1, dwell = 2, repeat = 1, phase_clr = 1.
  - Required: `phase_clr` pulses every 6 cycles, with no gap between the last value and the restarted start_fcw.
  - Abort at cycle 10: `fcw` = 0 and `busy` = 0 next cycle, no `done`.
- **Handshake rules:**
  - `cfg_valid` during RUN: `cfg_ready` = 0 and the sweep is unchanged.
  - `cfg_valid` + `start` in the same IDLE cycle: the sweep uses the new start_fcw.
  - `start` during RUN: ignored.
- **Reset mid-sweep:** assert `rst` for 1 cycle at step 2.
  - Required: all outputs at reset values next cycle.
  - A subsequent `start` without new config gives `fcw` = 0 (cleared config).
- **Degenerate:** nsteps = 0, dwell = 0, one-shot.
  - Required: `busy` for 1 cycle, `done` on the next cycle.
